// File: rtl/pid_pkg.sv
// Shared widths, pipeline stage structs and saturation helpers for the PDH PID loop filter.
package pid_pkg;

  localparam int PID_FRAC = 13;
  localparam int DAT_W    = 16;
  localparam int GAIN_W   = 16;
  localparam int SP_W     = 14;
  localparam int CNT_W    = 14;
  localparam int ERR_W    = 17;
  localparam int FLT_W    = 20;
  localparam int PROD_W   = GAIN_W + ERR_W;
  localparam int DPROD_W  = GAIN_W + FLT_W;
  localparam int ACC_W    = 40;
  localparam int SUM_W    = 40;

  // Captured on a tick: error sample plus the gain set it is processed with.
  typedef struct packed {
    logic [ERR_W-1:0]  err;
    logic [GAIN_W-1:0] kp;
    logic [GAIN_W-1:0] ki;
    logic [GAIN_W-1:0] kd;
    logic [3:0]        alpha;
    logic [3:0]        s;
  } stg1_t;

  typedef struct packed {
    logic [SUM_W-1:0] p;
    logic [SUM_W-1:0] i;
    logic [SUM_W-1:0] d;
    logic [3:0]       s;
  } stg2_t;

  function automatic logic [3:0] eff_s(input logic [4:0] w);
    return w[4] ? 4'hF : w[3:0];
  endfunction

  // Clamp to [-2^s, 2^s-1]; with s <= 15 the result always fits the output word.
  function automatic logic signed [DAT_W-1:0] sat_s(input logic signed [SUM_W-1:0] value,
                                                    input logic [3:0] s);
    logic signed [SUM_W-1:0] hi, lo, c;
    hi = $signed((SUM_W'(1) << s) - SUM_W'(1));
    lo = ~hi;
    if (value > hi)      c = hi;
    else if (value < lo) c = lo;
    else                 c = value;
    return c[DAT_W-1:0];
  endfunction

endpackage

// File: rtl/pid_decimator.sv
// Update-rate tick generator: fires when the free-running count reaches the programmed period.
module pid_decimator
  import pid_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_decimate,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit  = (r_cnt == i_decimate);
  assign o_tick = rst & i_enable & w_hit;

  // A period shortened below the live count wraps through 2^CNT_W-1 before matching.
  always_ff @(posedge clk) begin
    if (!rst || !i_enable) r_cnt <= '0;
    else if (w_hit)        r_cnt <= '0;
    else                   r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pdh_pid_core.sv
// Decimated PID loop filter: error capture, products with integrator/derivative-filter
// state update, then saturated sum with a one-cycle strobe.
module pdh_pid_core
  import pid_pkg::*;
#(
  parameter int FRAC = PID_FRAC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic signed [GAIN_W-1:0] kp_i,
  input  logic signed [GAIN_W-1:0] ki_i,
  input  logic signed [GAIN_W-1:0] kd_i,
  input  logic        [3:0]        alpha_i,
  input  logic signed [DAT_W-1:0]  dat_i,
  input  logic signed [SP_W-1:0]   sp_i,
  input  logic        [CNT_W-1:0]  decimate_i,
  input  logic        [4:0]        satwidth_i,
  output logic signed [DAT_W-1:0]  pid_out_o,
  output logic                     strobe_o
);

  logic                     w_clr, w_tick;
  logic [2:0]               r_vld_pipe;
  stg1_t                    r_s1;
  stg2_t                    r_s2;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [FLT_W-1:0]  r_flt;
  logic signed [ERR_W-1:0]  r_eprev;

  assign w_clr    = !rst || !enable_i;
  assign strobe_o = r_vld_pipe[2];

  pid_decimator u_dec (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (enable_i),
    .i_decimate (decimate_i),
    .o_tick     (w_tick)
  );

  // stage 0: error
  logic signed [ERR_W-1:0] w_err;
  assign w_err = {{(ERR_W-SP_W){sp_i[SP_W-1]}}, sp_i} - {dat_i[DAT_W-1], dat_i};

  // stage 1: products and state update
  logic signed [ERR_W-1:0]   w_e1;
  logic signed [PROD_W-1:0]  w_prod_p, w_prod_i;
  logic signed [ACC_W-1:0]   w_acc_sum, w_acc_hi, w_acc_lo, w_acc_nxt;
  logic signed [FLT_W-1:0]   w_diff, w_fd, w_flt_nxt;
  logic signed [DPROD_W-1:0] w_prod_d;
  logic signed [SUM_W-1:0]   w_p, w_i, w_d;

  assign w_e1     = $signed(r_s1.err);
  assign w_prod_p = $signed({{ERR_W{r_s1.kp[GAIN_W-1]}}, r_s1.kp}) *
                    $signed({{GAIN_W{w_e1[ERR_W-1]}}, w_e1});
  assign w_prod_i = $signed({{ERR_W{r_s1.ki[GAIN_W-1]}}, r_s1.ki}) *
                    $signed({{GAIN_W{w_e1[ERR_W-1]}}, w_e1});

  assign w_acc_sum = r_acc + $signed({{(ACC_W-PROD_W){w_prod_i[PROD_W-1]}}, w_prod_i});
  assign w_acc_hi  = $signed(((ACC_W'(1) << r_s1.s) - ACC_W'(1)) << FRAC);
  assign w_acc_lo  = $signed(ACC_W'(0) - ((ACC_W'(1) << r_s1.s) << FRAC));
  // Anti-windup: the stored accumulator itself is clamped, so it never remembers overshoot.
  assign w_acc_nxt = (w_acc_sum > w_acc_hi) ? w_acc_hi :
                     (w_acc_sum < w_acc_lo) ? w_acc_lo : w_acc_sum;

  assign w_diff    = {{(FLT_W-ERR_W){w_e1[ERR_W-1]}}, w_e1} -
                     {{(FLT_W-ERR_W){r_eprev[ERR_W-1]}}, r_eprev};
  assign w_fd      = w_diff - r_flt;
  assign w_flt_nxt = r_flt + (w_fd >>> r_s1.alpha);
  assign w_prod_d  = $signed({{FLT_W{r_s1.kd[GAIN_W-1]}}, r_s1.kd}) *
                     $signed({{GAIN_W{w_flt_nxt[FLT_W-1]}}, w_flt_nxt});

  assign w_p = $signed({{(SUM_W-PROD_W){w_prod_p[PROD_W-1]}}, w_prod_p}) >>> FRAC;
  assign w_i = w_acc_nxt >>> FRAC;
  assign w_d = $signed({{(SUM_W-DPROD_W){w_prod_d[DPROD_W-1]}}, w_prod_d}) >>> FRAC;

  // stage 2: saturated sum
  logic signed [SUM_W-1:0] w_sum;
  logic signed [DAT_W-1:0] w_out;
  assign w_sum = $signed(r_s2.p) + $signed(r_s2.i) + $signed(r_s2.d);
  assign w_out = sat_s(w_sum, r_s2.s);

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_acc      <= '0;
      r_flt      <= '0;
      r_eprev    <= '0;
      pid_out_o  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1:0], w_tick};
      if (w_tick) begin
        r_s1.err   <= w_err;
        r_s1.kp    <= kp_i;
        r_s1.ki    <= ki_i;
        r_s1.kd    <= kd_i;
        r_s1.alpha <= alpha_i;
        r_s1.s     <= eff_s(satwidth_i);
      end
      // State commits here so a tick on the very next cycle already sees it.
      if (r_vld_pipe[0]) begin
        r_acc   <= w_acc_nxt;
        r_flt   <= w_flt_nxt;
        r_eprev <= w_e1;
        r_s2.p  <= w_p;
        r_s2.i  <= w_i;
        r_s2.d  <= w_d;
        r_s2.s  <= r_s1.s;
      end
      if (r_vld_pipe[1]) pid_out_o <= w_out;
    end
  end

endmodule

// File: tb/tb_pdh_pid_core.sv
// Directed bench for pdh_pid_core: reset/latency, P, I with anti-windup, D filter,
// disable mid-pipeline and a combined run against a reference model.
module tb_pdh_pid_core;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable_i;
  logic signed [15:0] kp_i, ki_i, kd_i, dat_i;
  logic        [3:0]  alpha_i;
  logic signed [13:0] sp_i;
  logic        [13:0] decimate_i;
  logic        [4:0]  satwidth_i;
  logic signed [15:0] pid_out_o;
  logic               strobe_o;

  int n_chk  = 0;
  int n_fail = 0;

  longint m_acc, m_flt, m_ep;

  always #5 clk = ~clk;

  pdh_pid_core #(.FRAC(13)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable_i),
    .kp_i       (kp_i),
    .ki_i       (ki_i),
    .kd_i       (kd_i),
    .alpha_i    (alpha_i),
    .dat_i      (dat_i),
    .sp_i       (sp_i),
    .decimate_i (decimate_i),
    .satwidth_i (satwidth_i),
    .pid_out_o  (pid_out_o),
    .strobe_o   (strobe_o)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!strobe_o && n < 50);
    chk("strobe_seen", 32'(strobe_o), 1);
  endtask

  task automatic restart();
    enable_i = 1'b0;
    @(posedge clk); #1;
    enable_i = 1'b1;
  endtask

  task automatic expect_next(input string tag, input int exp);
    int n;
    wait_strobe(n);
    chk(tag, pid_out_o, exp);
  endtask

  task automatic model_step(input longint dat, input longint sp, input longint kp,
                            input longint ki, input longint kd, input int alpha,
                            input int s, output longint y);
    longint e, p, i, d, diff, sum, hi, lo;
    e     = sp - dat;
    p     = (kp * e) >>> 13;
    m_acc = m_acc + ki * e;
    hi    = ((64'sd1 << s) - 1) * 8192;
    lo    = -(64'sd1 << s) * 8192;
    if (m_acc > hi) m_acc = hi;
    if (m_acc < lo) m_acc = lo;
    i     = m_acc >>> 13;
    diff  = e - m_ep;
    m_flt = m_flt + ((diff - m_flt) >>> alpha);
    d     = (kd * m_flt) >>> 13;
    m_ep  = e;
    sum   = p + i + d;
    hi    = (64'sd1 << s) - 1;
    lo    = -(64'sd1 << s);
    y     = (sum > hi) ? hi : (sum < lo) ? lo : sum;
  endtask

  initial begin
    int n;
    longint y;
    rst = 1'b0; enable_i = 1'b1;
    kp_i = 0; ki_i = 0; kd_i = 0; alpha_i = 0;
    dat_i = 0; sp_i = 0; decimate_i = 14'd2; satwidth_i = 5'd15;

    // reset holds everything at zero even with enable high
    repeat (5) begin
      @(posedge clk); #1;
      chk("rst_out", pid_out_o, 0);
      chk("rst_strobe", 32'(strobe_o), 0);
    end
    rst = 1'b1;
    wait_strobe(n);  chk("first_latency", n, 5);
    wait_strobe(n);  chk("period", n, 3);
    @(posedge clk); #1;
    chk("strobe_one_cycle", 32'(strobe_o), 0);

    // proportional only
    kp_i = 16'sh2000; dat_i = 16'sd8192; sp_i = 0; satwidth_i = 5'd15;
    restart();
    expect_next("p_unity", -8192);
    kp_i = 16'sh3FFF; dat_i = -16'sd8192; satwidth_i = 5'd12;
    expect_next("p_sat_hi", 4095);
    satwidth_i = 5'd15;
    expect_next("p_nosat", 16383);
    dat_i = 16'sd8192; satwidth_i = 5'd12;
    expect_next("p_sat_lo", -4096);

    // integral with anti-windup
    kp_i = 0; ki_i = 16'sh2000; dat_i = 0; sp_i = 14'sd10; satwidth_i = 5'd15;
    restart();
    expect_next("i_10", 10);
    expect_next("i_20", 20);
    expect_next("i_30", 30);
    satwidth_i = 5'd5;
    expect_next("i_clamp", 31);
    expect_next("i_clamp_hold", 31);
    sp_i = -14'sd10;
    expect_next("i_no_windup", 21);

    // disable one cycle after a tick: in-flight result discarded, integrator restarts
    @(posedge clk); #1;
    enable_i = 1'b0;
    @(posedge clk); #1;
    chk("dis_out", pid_out_o, 0);
    chk("dis_strobe", 32'(strobe_o), 0);
    enable_i = 1'b1; sp_i = 14'sd10; satwidth_i = 5'd15;
    wait_strobe(n);  chk("reen_latency", n, 5);
    chk("reen_i_10", pid_out_o, 10);
    expect_next("reen_i_20", 20);

    // derivative, unfiltered and alpha=2
    ki_i = 0; kd_i = 16'sh2000; sp_i = 0; dat_i = 0; alpha_i = 4'd0;
    restart();
    expect_next("d_zero", 0);
    dat_i = -16'sd100;
    expect_next("d_step", 100);
    expect_next("d_settle", 0);
    alpha_i = 4'd2; dat_i = 0;
    restart();
    expect_next("df_zero", 0);
    dat_i = -16'sd100;
    expect_next("df_25", 25);
    expect_next("df_18", 18);
    expect_next("df_13", 13);
    alpha_i = 4'd0;
    restart();
    expect_next("d_eprev_clear", 100);

    // combined run against the reference model
    kp_i = 16'sh3FFF; ki_i = 16'sh1FFF; kd_i = 16'sh1FFF; alpha_i = 4'd2; satwidth_i = 5'd15;
    dat_i = 16'sd8192; sp_i = 14'sd10;
    m_acc = 0; m_flt = 0; m_ep = 0;
    restart();
    for (int k = 0; k < 10; k++) begin
      model_step(longint'(dat_i), longint'(sp_i), 16383, 8191, 8191, 2, 15, y);
      wait_strobe(n);
      chk($sformatf("combined_%0d", k), pid_out_o, 32'(y));
      dat_i = (k % 2 == 0) ? -16'sd8192 : 16'sd8192;
      sp_i  = ((k + 1) % 4 < 2) ? 14'sd10 : -14'sd10;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
